// File: rtl/lcd_syncgen.sv
// Timing generator for a parallel RGB565 panel: filters PLL lock and sweeps the raster.
// It requests pixels one clock ahead of use and drives DE/syncs/RGB aligned two clocks later.
module lcd_syncgen #(
  parameter int unsigned H_SYNC    = 4,
  parameter int unsigned H_BACK    = 43,
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FRONT   = 8,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 12,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FRONT   = 8,
  parameter int unsigned LOCK_WAIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pll_lock,
  output logic        pixel_req,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        frame_top,
  input  logic [15:0] pixel_data,
  output logic        lcd_de,
  output logic        lcd_hsync_n,
  output logic        lcd_vsync_n,
  output logic [15:0] lcd_rgb
);

  localparam int unsigned HT          = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned VT          = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
  localparam logic [9:0]  H_LAST      = 10'(HT - 1);
  localparam logic [9:0]  V_LAST      = 10'(VT - 1);
  localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_WAIT - 1);

  logic       lock_meta;
  logic       lock_sync;
  logic [7:0] lock_cnt;
  logic       run;
  logic       idle;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_sync;
  logic       v_sync;
  logic       h_act;
  logic       v_act;
  logic       act;
  logic       at_origin;
  logic       hs0;
  logic       vs0;
  logic       req1;
  logic       hs1;
  logic       vs1;

  assign idle = reset || !run;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // Any synced low restarts the wait and drops run on the same edge.
  always_ff @(posedge clk) begin
    if (reset || !lock_sync) begin
      lock_cnt <= 8'd0;
      run      <= 1'b0;
    end else if (!run) begin
      if (lock_cnt == LOCK_LAST) run <= 1'b1;
      else                       lock_cnt <= lock_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (idle) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (hcount == H_LAST) begin
      hcount <= 10'd0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  always_comb begin
    h_sync    = hcount < 10'(H_SYNC);
    v_sync    = vcount < 10'(V_SYNC);
    h_act     = ({1'b0, hcount} >= 11'(H_ACT_START)) && ({1'b0, hcount} < 11'(H_ACT_END));
    v_act     = ({1'b0, vcount} >= 11'(V_ACT_START)) && ({1'b0, vcount} < 11'(V_ACT_END));
    act       = h_act && v_act;
    at_origin = (hcount == 10'(H_ACT_START)) && (vcount == 10'(V_ACT_START));
  end

  // Request contract: pixel_req/x/y name one pixel; the source must present its
  // pixel_data on the following clock, with no back-pressure and no skipping.
  always_ff @(posedge clk) begin
    if (idle) begin
      pixel_req <= 1'b0;
      pixel_x   <= 9'd0;
      pixel_y   <= 9'd0;
      frame_top <= 1'b0;
      hs0       <= 1'b0;
      vs0       <= 1'b0;
    end else begin
      pixel_req <= act;
      pixel_x   <= act ? 9'(hcount - 10'(H_ACT_START)) : 9'd0;
      pixel_y   <= act ? 9'(vcount - 10'(V_ACT_START)) : 9'd0;
      frame_top <= act && at_origin;
      hs0       <= h_sync;
      vs0       <= v_sync;
    end
  end

  // Delay line is flushed as soon as run drops so the panel sees idle levels quickly.
  always_ff @(posedge clk) begin
    if (idle) begin
      req1        <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_rgb     <= 16'd0;
    end else begin
      req1        <= pixel_req;
      hs1         <= hs0;
      vs1         <= vs0;
      lcd_de      <= req1;
      lcd_hsync_n <= ~hs1;
      lcd_vsync_n <= ~vs1;
      lcd_rgb     <= req1 ? pixel_data : 16'd0;
    end
  end

endmodule
